// File: rtl/btb_update_queue.sv
// btb_update_queue
//   Small FIFO that buffers BTB corrections discovered at branch resolution
//   until the BTB write port is free. A resolve whose prediction was wrong
//   becomes an entry {pc, jump=taken, target}. A later correction for the
//   same pc[31:2] overwrites the queued entry in place instead of taking a
//   second slot.
//
// Ports
//   clock                       rising-edge clock
//   reset                       asynchronous, active-low reset
//   io_resolve_valid/ready      resolve handshake (see below)
//   io_resolve_bits_*           resolved pc/direction/target plus the BTB
//                               response captured at fetch
//   io_drain_en                 BTB write port is available this cycle
//   io_flush                    drop every queued update
//   io_write_valid/bits_*       BTB write request taken from the head entry
//   io_count                    registered occupancy
//
// Handshake: a resolve transfers on a rising edge when io_resolve_valid and
// io_resolve_ready are both 1 and io_flush is 0. io_resolve_ready is ~full
// and never looks at a same-cycle pop. The write side has no ready: the BTB
// always takes a request, so io_write_valid=1 pops the head on that edge.
module btb_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_resolve_valid,
    output logic                       io_resolve_ready,
    input  logic [31:0]                io_resolve_bits_pc,
    input  logic                       io_resolve_bits_is_branch,
    input  logic                       io_resolve_bits_taken,
    input  logic [31:0]                io_resolve_bits_target,
    input  logic                       io_resolve_bits_pred_hit,
    input  logic                       io_resolve_bits_pred_jump,
    input  logic [31:0]                io_resolve_bits_pred_target,
    input  logic                       io_drain_en,
    input  logic                       io_flush,
    output logic                       io_write_valid,
    output logic [31:0]                io_write_bits_pc,
    output logic                       io_write_bits_jump,
    output logic [31:0]                io_write_bits_target,
    output logic [$clog2(DEPTH):0]     io_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; contents are meaningful only where entry_valid is set.
    logic [31:0]      pc_q     [DEPTH];
    logic             jump_q   [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [DEPTH-1:0] entry_valid_q;

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic             full;
    logic             empty;
    logic             need_update;
    logic             accept;
    logic             pop;
    logic             enq;
    logic             merge_hit;
    logic [DEPTH-1:0] merge_mask;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // The BTB needs a write when a taken branch was not predicted as a hit
    // to the same target, or when a predicted-taken entry turned out not taken.
    assign need_update = io_resolve_bits_is_branch &
        ((io_resolve_bits_taken &
          (~io_resolve_bits_pred_hit | ~io_resolve_bits_pred_jump |
           (io_resolve_bits_pred_target != io_resolve_bits_target))) |
         (io_resolve_bits_pred_hit & io_resolve_bits_pred_jump &
          ~io_resolve_bits_taken));

    assign io_resolve_ready = ~full;
    assign accept           = io_resolve_valid & io_resolve_ready & ~io_flush;

    assign io_write_valid       = ~empty & io_drain_en & ~io_flush;
    assign pop                  = io_write_valid;
    assign io_write_bits_pc     = pc_q[head_q];
    assign io_write_bits_jump   = jump_q[head_q];
    assign io_write_bits_target = target_q[head_q];

    // The head leaving this cycle must not absorb the update, otherwise the
    // correction would be lost with it; it goes to the tail instead.
    always_comb begin
        merge_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_q[i] &&
                (pc_q[i][31:2] == io_resolve_bits_pc[31:2]) &&
                !(pop && (head_q == PW'(i)))) begin
                merge_mask[i] = 1'b1;
            end
        end
    end

    assign merge_hit = accept & need_update & (|merge_mask);
    assign enq       = accept & need_update & ~(|merge_mask);

    assign io_count = count_q;

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            entry_valid_q <= '0;
        end else if (io_flush) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            entry_valid_q <= '0;
        end else begin
            // head and tail never coincide when both pop and enq happen,
            // since that would need the queue to be full or empty.
            if (pop) begin
                entry_valid_q[head_q] <= 1'b0;
                head_q                <= head_q + PW'(1);
            end
            if (enq) begin
                entry_valid_q[tail_q] <= 1'b1;
                tail_q                <= tail_q + PW'(1);
            end
            case ({enq, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry data carries no reset; entry_valid_q guards every use of it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (merge_hit && merge_mask[i]) begin
                jump_q[i]   <= io_resolve_bits_taken;
                target_q[i] <= io_resolve_bits_target;
            end
        end
        if (enq) begin
            pc_q[tail_q]     <= io_resolve_bits_pc;
            jump_q[tail_q]   <= io_resolve_bits_taken;
            target_q[tail_q] <= io_resolve_bits_target;
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// tb_btb_update_queue
//   Directed bench for btb_update_queue (DEPTH=4). Inputs change 1ns after a
//   rising edge; combinational outputs are checked in the same cycle before
//   the next edge and io_count is checked 1ns after the edge that updates it.
module tb_btb_update_queue;

    logic        clock;
    logic        reset;
    logic        io_resolve_valid;
    logic        io_resolve_ready;
    logic [31:0] io_resolve_bits_pc;
    logic        io_resolve_bits_is_branch;
    logic        io_resolve_bits_taken;
    logic [31:0] io_resolve_bits_target;
    logic        io_resolve_bits_pred_hit;
    logic        io_resolve_bits_pred_jump;
    logic [31:0] io_resolve_bits_pred_target;
    logic        io_drain_en;
    logic        io_flush;
    logic        io_write_valid;
    logic [31:0] io_write_bits_pc;
    logic        io_write_bits_jump;
    logic [31:0] io_write_bits_target;
    logic [2:0]  io_count;

    int total = 0;
    int bad   = 0;

    btb_update_queue #(.DEPTH(4)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .io_resolve_valid            (io_resolve_valid),
        .io_resolve_ready            (io_resolve_ready),
        .io_resolve_bits_pc          (io_resolve_bits_pc),
        .io_resolve_bits_is_branch   (io_resolve_bits_is_branch),
        .io_resolve_bits_taken       (io_resolve_bits_taken),
        .io_resolve_bits_target      (io_resolve_bits_target),
        .io_resolve_bits_pred_hit    (io_resolve_bits_pred_hit),
        .io_resolve_bits_pred_jump   (io_resolve_bits_pred_jump),
        .io_resolve_bits_pred_target (io_resolve_bits_pred_target),
        .io_drain_en                 (io_drain_en),
        .io_flush                    (io_flush),
        .io_write_valid              (io_write_valid),
        .io_write_bits_pc            (io_write_bits_pc),
        .io_write_bits_jump          (io_write_bits_jump),
        .io_write_bits_target        (io_write_bits_target),
        .io_count                    (io_count)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_resolve();
        io_resolve_valid            = 1'b0;
        io_resolve_bits_pc          = '0;
        io_resolve_bits_is_branch   = 1'b0;
        io_resolve_bits_taken       = 1'b0;
        io_resolve_bits_target      = '0;
        io_resolve_bits_pred_hit    = 1'b0;
        io_resolve_bits_pred_jump   = 1'b0;
        io_resolve_bits_pred_target = '0;
    endtask

    task automatic drive_resolve(input logic [31:0] pc, input logic is_branch, input logic taken,
                                 input logic [31:0] target, input logic hit, input logic pjump,
                                 input logic [31:0] ptarget);
        io_resolve_valid            = 1'b1;
        io_resolve_bits_pc          = pc;
        io_resolve_bits_is_branch   = is_branch;
        io_resolve_bits_taken       = taken;
        io_resolve_bits_target      = target;
        io_resolve_bits_pred_hit    = hit;
        io_resolve_bits_pred_jump   = pjump;
        io_resolve_bits_pred_target = ptarget;
    endtask

    // Taken branch that missed in the BTB: always needs an update.
    task automatic drive_miss(input logic [31:0] pc, input logic [31:0] target);
        drive_resolve(pc, 1'b1, 1'b1, target, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_write(input string tag, input logic [31:0] pc, input logic jump,
                               input logic [31:0] target);
        check({tag, "_wvalid"}, {31'b0, io_write_valid}, 32'd1);
        check({tag, "_wpc"}, io_write_bits_pc, pc);
        check({tag, "_wjump"}, {31'b0, io_write_bits_jump}, {31'b0, jump});
        check({tag, "_wtarget"}, io_write_bits_target, target);
    endtask

    initial begin
        reset       = 1'b0;
        io_drain_en = 1'b1;
        io_flush    = 1'b0;
        idle_resolve();

        // Reset state, with drain requested to show it is masked.
        #12;
        check("rst_ready", {31'b0, io_resolve_ready}, 32'd1);
        check("rst_wvalid", {31'b0, io_write_valid}, 32'd0);
        check("rst_count", {29'b0, io_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Correct prediction: consumed, nothing queued.
        drive_resolve(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);
        #1;
        check("ok_ready", {31'b0, io_resolve_ready}, 32'd1);
        tick();
        idle_resolve();
        check("ok_count", {29'b0, io_count}, 32'd0);
        check("ok_wvalid", {31'b0, io_write_valid}, 32'd0);

        // Not a branch: consumed silently.
        drive_resolve(32'h180, 1'b0, 1'b1, 32'h280, 1'b0, 1'b0, 32'h0);
        tick();
        idle_resolve();
        check("nb_count", {29'b0, io_count}, 32'd0);

        // Miss then drain.
        drive_miss(32'h100, 32'h200);
        #1;
        check("miss_wvalid0", {31'b0, io_write_valid}, 32'd0);
        tick();
        idle_resolve();
        check("miss_count", {29'b0, io_count}, 32'd1);
        check_write("miss", 32'h100, 1'b1, 32'h200);
        tick();
        check("miss_count_after", {29'b0, io_count}, 32'd0);
        check("miss_wvalid_after", {31'b0, io_write_valid}, 32'd0);

        // Predicted taken but not taken: entry with jump=0.
        io_drain_en = 1'b0;
        drive_resolve(32'h300, 1'b1, 1'b0, 32'h304, 1'b1, 1'b1, 32'h400);
        tick();
        idle_resolve();
        check("nt_count", {29'b0, io_count}, 32'd1);
        io_drain_en = 1'b1;
        #1;
        check_write("nt", 32'h300, 1'b0, 32'h304);
        tick();
        check("nt_count_after", {29'b0, io_count}, 32'd0);

        // Merge: the second update for the same pc overwrites the target.
        io_drain_en = 1'b0;
        drive_miss(32'h40, 32'h80);
        tick();
        drive_resolve(32'h40, 1'b1, 1'b1, 32'hC0, 1'b1, 1'b1, 32'h80);
        tick();
        idle_resolve();
        check("merge_count", {29'b0, io_count}, 32'd1);
        io_drain_en = 1'b1;
        #1;
        check_write("merge", 32'h40, 1'b1, 32'hC0);
        tick();
        check("merge_count_after", {29'b0, io_count}, 32'd0);
        check("merge_single_write", {31'b0, io_write_valid}, 32'd0);

        // Full: four entries, a fifth held until space frees.
        io_drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_miss(32'(i) << 12, (32'(i) << 12) + 32'h4);
            tick();
        end
        check("full_count", {29'b0, io_count}, 32'd4);
        check("full_ready", {31'b0, io_resolve_ready}, 32'd0);
        drive_miss(32'h5000, 32'h5004);
        tick();
        check("full_held_count", {29'b0, io_count}, 32'd4);
        io_drain_en = 1'b1;
        #1;
        check("full_ready_popcycle", {31'b0, io_resolve_ready}, 32'd0);
        check_write("full_w1", 32'h1000, 1'b1, 32'h1004);
        tick();
        check("full_count_w1", {29'b0, io_count}, 32'd3);
        check("full_ready_w1", {31'b0, io_resolve_ready}, 32'd1);
        check_write("full_w2", 32'h2000, 1'b1, 32'h2004);
        tick();
        idle_resolve();
        check("full_count_w2", {29'b0, io_count}, 32'd3);
        for (int i = 3; i <= 5; i++) begin
            check_write("full_wn", 32'(i) << 12, 1'b1, (32'(i) << 12) + 32'h4);
            tick();
            check("full_count_wn", {29'b0, io_count}, 32'(5 - i));
        end

        // Update for the head being popped goes to the tail, not a merge.
        io_drain_en = 1'b0;
        drive_miss(32'h600, 32'h610);
        tick();
        io_drain_en = 1'b1;
        drive_miss(32'h600, 32'h700);
        #1;
        check_write("xhead_w1", 32'h600, 1'b1, 32'h610);
        tick();
        idle_resolve();
        check("xhead_count", {29'b0, io_count}, 32'd1);
        check_write("xhead_w2", 32'h600, 1'b1, 32'h700);
        tick();
        check("xhead_count_after", {29'b0, io_count}, 32'd0);

        // Flush with three entries, a pending resolve and drain requested.
        io_drain_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_miss(32'h8000 + (32'(i) << 4), 32'h9000);
            tick();
        end
        check("flush_pre_count", {29'b0, io_count}, 32'd3);
        io_drain_en = 1'b1;
        io_flush    = 1'b1;
        drive_miss(32'hA000, 32'hB000);
        #1;
        check("flush_wvalid", {31'b0, io_write_valid}, 32'd0);
        tick();
        io_flush = 1'b0;
        idle_resolve();
        check("flush_count", {29'b0, io_count}, 32'd0);
        check("flush_wvalid_after", {31'b0, io_write_valid}, 32'd0);

        // Reset asserted mid-drain.
        io_drain_en = 1'b0;
        drive_miss(32'hC000, 32'hC100);
        tick();
        drive_miss(32'hD000, 32'hD100);
        tick();
        idle_resolve();
        io_drain_en = 1'b1;
        #1;
        check_write("rdrain", 32'hC000, 1'b1, 32'hC100);
        tick();
        check("rdrain_count", {29'b0, io_count}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rdrain_wvalid", {31'b0, io_write_valid}, 32'd0);
        check("rdrain_count_rst", {29'b0, io_count}, 32'd0);
        check("rdrain_ready", {31'b0, io_resolve_ready}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_wvalid", {31'b0, io_write_valid}, 32'd0);
        check("post_rst_count", {29'b0, io_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_update_queue.md
BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2..8.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port io_resolve_valid, input, 1 bit: a resolved control-flow instruction is presented.
REQ-005 SHALL have port io_resolve_ready, output, 1 bit: the queue accepts the resolve this cycle.
REQ-006 SHALL have port io_resolve_bits_pc, input, 32 bits: PC of the resolved instruction.
REQ-007 SHALL have port io_resolve_bits_is_branch, input, 1 bit: the instruction is a branch or jump.
REQ-008 SHALL have port io_resolve_bits_taken, input, 1 bit: actual direction.
REQ-009 SHALL have port io_resolve_bits_target, input, 32 bits: actual target.
REQ-010 SHALL have ports io_resolve_bits_pred_hit (1 bit), io_resolve_bits_pred_jump (1 bit) and io_resolve_bits_pred_target (32 bits), all inputs: the BTB read response captured at fetch.
REQ-011 SHALL have port io_drain_en, input, 1 bit: BTB write port permitted this cycle.
REQ-012 SHALL have port io_flush, input, 1 bit: discard all queued updates.
REQ-013 SHALL have ports io_write_valid (1 bit), io_write_bits_pc (32 bits), io_write_bits_jump (1 bit) and io_write_bits_target (32 bits), all outputs: the BTB write request.
REQ-014 SHALL have port io_count, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 SHALL compute need_update = is_branch & ((taken & (~pred_hit | ~pred_jump | pred_target != target)) | (pred_hit & pred_jump & ~taken)).
REQ-016 SHALL form each entry as {pc, jump=taken, target}; the full 32-bit pc is stored.
REQ-017 SHALL drive io_resolve_ready = ~full; ready SHALL NOT depend on a same-cycle pop.
REQ-018 SHALL treat a resolve as accepted only when io_resolve_valid & io_resolve_ready & ~io_flush.
REQ-019 SHALL silently consume an accepted resolve with need_update=0; queue state SHALL be unchanged.
REQ-020 SHALL merge an accepted resolve with need_update=1 when pc[31:2] matches a queued entry: jump and target are overwritten in place; count and order are unchanged.
REQ-021 SHALL exclude from merge matching the head entry being popped in the same cycle; in that case the resolve is enqueued as a new entry at the tail.
REQ-022 SHALL enqueue a resolve with need_update=1 and no merge at the tail; count increments by 1.
REQ-023 SHALL drive io_write_valid = ~empty & io_drain_en combinationally, with io_write_bits_* taken from the head entry; bits are don't-care when io_write_valid=0.
REQ-024 SHALL pop the head on the same rising edge whenever io_write_valid=1; the write port always accepts.
REQ-025 SHALL, on a same-cycle enqueue and pop, leave count unchanged; head and tail pointers each advance.
REQ-026 SHALL wrap head and tail pointers modulo DEPTH; full means count==DEPTH and empty means count==0.
REQ-027 SHALL, with io_flush=1, drive io_write_valid=0, ignore any resolve, and set count to 0 and both pointers to 0 at the next edge.
REQ-028 SHALL drive io_count from a register, never combinationally.

Reset
REQ-029 SHALL, while reset=0, asynchronously clear count and both pointers and invalidate all entries, forcing io_write_valid=0, io_resolve_ready=1 and io_count=0.
REQ-030 SHALL discard any partially drained queue on reset mid-operation; no write is issued in the first cycle after release unless an enqueue occurred first.
REQ-031 SHALL NOT require entry data storage to be reset.

Verification
REQ-032 Correct prediction: pc=0x100, is_branch=1, taken=1, pred_hit=1, pred_jump=1, pred_target=target=0x200 -> accepted, io_count stays 0, no write.
REQ-033 Miss then drain: pc=0x100, taken=1, target=0x200, pred_hit=0, drain_en=1 -> next cycle write_valid=1 with pc=0x100, jump=1, target=0x200; following cycle count=0.
REQ-034 Merge: with drain_en=0, enqueue pc=0x40 target=0x80, then pc=0x40 target=0xC0 -> count=1; after drain_en=1 a single write with target=0xC0.
REQ-035 Full: with drain_en=0, 4 distinct mispredicts -> count=4, ready=0; a 5th resolve is held; after drain_en=1 for 1 cycle, ready=1 and writes emerge in FIFO order.
REQ-036 Flush plus reset: 3 entries queued, then io_flush=1 -> count=0, no write; separately, reset=0 asserted mid-drain -> write_valid drops immediately and count=0.
